// File: rtl/reg_file_rename_pkg.sv
// reg_file_rename_pkg: shared widths and types for the renaming register file.
package reg_file_rename_pkg;
    localparam int REG_NUM     = 32;
    localparam int REG_IDX_BIT = 5;
    localparam int ROB_TAG_BIT = 4;
    localparam int XLEN        = 32;

    typedef logic [REG_IDX_BIT-1:0] reg_idx_t;
    typedef logic [ROB_TAG_BIT-1:0] tag_t;
    typedef logic [XLEN-1:0]        word_t;
endpackage

// File: rtl/reg_file_rename_read_port.sv
// reg_file_rename_read_port: one operand lookup, resolving the architectural value,
// a same-cycle commit bypass, a ready ROB entry, or the tag still to wait on.
module reg_file_rename_read_port
    import reg_file_rename_pkg::*;
(
    input  reg_idx_t rs,
    input  word_t    reg_val,
    input  logic     reg_busy,
    input  tag_t     reg_tag,
    input  logic     commit_valid,
    input  tag_t     commit_rob_id,
    input  word_t    commit_val,
    input  logic     rob_ready,
    input  word_t    rob_val,
    output tag_t     rob_id,
    output word_t    val,
    output logic     has_dep,
    output tag_t     dep
);
    logic live;
    logic bypass;

    always_comb begin
        live    = (rs != '0) && reg_busy;
        bypass  = live && commit_valid && (commit_rob_id == reg_tag);
        has_dep = live && !bypass && !rob_ready;
        rob_id  = (rs == '0) ? '0 : reg_tag;
        dep     = rob_id;
        val     = !live   ? ((rs == '0) ? '0 : reg_val) :
                  bypass  ? commit_val :
                  rob_ready ? rob_val : '0;
    end
endmodule

// File: rtl/reg_file_rename.sv
// reg_file_rename: architectural register file with per-register ROB rename tags,
// retired on commit, flushed on mispredict, looked up combinationally by the decoder.
module reg_file_rename
    import reg_file_rename_pkg::*;
(
    input  logic     clk_in,
    input  logic     rst_in,
    input  logic     rdy_in,
    input  logic     clear_flag,
    input  reg_idx_t commit_rd,
    input  word_t    commit_val,
    input  tag_t     commit_rob_id,
    input  reg_idx_t rename_rd,
    input  tag_t     rename_rob_id,
    input  reg_idx_t dec_rs1,
    input  reg_idx_t dec_rs2,
    output tag_t     rob_rs1_id,
    input  logic     rob_rs1_ready,
    input  word_t    rob_rs1_val,
    output tag_t     rob_rs2_id,
    input  logic     rob_rs2_ready,
    input  word_t    rob_rs2_val,
    output word_t    rs1_val,
    output logic     rs1_has_dep,
    output tag_t     rs1_dep,
    output word_t    rs2_val,
    output logic     rs2_has_dep,
    output tag_t     rs2_dep
);
    word_t val  [REG_NUM];
    logic  busy [REG_NUM];
    tag_t  tag  [REG_NUM];

    // x0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val[i]  <= '0;
                busy[i] <= 1'b0;
                tag[i]  <= '0;
            end
        end else if (rdy_in) begin
            for (int i = 1; i < REG_NUM; i++) begin
                if (commit_rd == REG_IDX_BIT'(i))
                    val[i] <= commit_val;
                if (clear_flag) begin
                    busy[i] <= 1'b0;
                    tag[i]  <= '0;
                end else if (rename_rd == REG_IDX_BIT'(i)) begin
                    busy[i] <= 1'b1;
                    tag[i]  <= rename_rob_id;
                end else if (commit_rd == REG_IDX_BIT'(i) && busy[i] && tag[i] == commit_rob_id) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    reg_file_rename_read_port u_rs1 (
        .rs            (dec_rs1),
        .reg_val       (val[dec_rs1]),
        .reg_busy      (busy[dec_rs1]),
        .reg_tag       (tag[dec_rs1]),
        .commit_valid  (commit_rd != '0),
        .commit_rob_id (commit_rob_id),
        .commit_val    (commit_val),
        .rob_ready     (rob_rs1_ready),
        .rob_val       (rob_rs1_val),
        .rob_id        (rob_rs1_id),
        .val           (rs1_val),
        .has_dep       (rs1_has_dep),
        .dep           (rs1_dep)
    );

    reg_file_rename_read_port u_rs2 (
        .rs            (dec_rs2),
        .reg_val       (val[dec_rs2]),
        .reg_busy      (busy[dec_rs2]),
        .reg_tag       (tag[dec_rs2]),
        .commit_valid  (commit_rd != '0),
        .commit_rob_id (commit_rob_id),
        .commit_val    (commit_val),
        .rob_ready     (rob_rs2_ready),
        .rob_val       (rob_rs2_val),
        .rob_id        (rob_rs2_id),
        .val           (rs2_val),
        .has_dep       (rs2_has_dep),
        .dep           (rs2_dep)
    );
endmodule
